iir_biquad_mac_sequencer: RTL



---
 rtl/iir_biquad_mac_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/iir_biquad_mac_sequencer.sv
// Time-multiplexed Direct Form I biquad sequencer driving one shared multiplier.
// y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2]
// Optional build macro IIR_SAT_EN: saturate out-of-range results (default wraps).
module iir_biquad_mac_sequencer #(
  parameter int unsigned DW = 16,
  parameter int unsigned DF = 12,
  parameter int unsigned CW = 16,
  parameter int unsigned CF = 14,
  parameter int unsigned GW = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  input  logic             coef_wr,
  input  logic [2:0]       coef_addr,
  input  logic [CW-1:0]    coef_data,
  output logic [DW-1:0]    mul_a,
  output logic [CW-1:0]    mul_b,
  input  logic [DW+CW-1:0] mul_p,
  input  logic             mul_ovf,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam int unsigned PW    = DW + CW;
  localparam int unsigned AW    = PW + GW;
  // Product carries DF+CF fraction bits; the output keeps DF of them.
  localparam int unsigned SHIFT = (DF + CF) - DF;
  localparam int unsigned NC    = 5;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_e;

  state_e               state_q, state_d;
  logic [2:0]           tap_q, tap_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [DW-1:0]        x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
  logic [DW-1:0]        y1_q, y1_d, y2_q, y2_d;
  logic [CW-1:0]        shadow_q [NC];
  logic [CW-1:0]        shadow_d [NC];
  logic [CW-1:0]        active_q [NC];
  logic [CW-1:0]        active_d [NC];
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [DW-1:0]        out_data_q, out_data_d;
  logic [DW-1:0]        mul_a_q, mul_a_d;
  logic [CW-1:0]        mul_b_q, mul_b_d;
  logic                 ovf_q, ovf_d;
  logic                 ovf_set;

  logic signed [AW-1:0] p_ext;
  logic signed [AW-1:0] acc_sum;
  logic signed [AW-1:0] q_full;
  logic [AW-DW:0]       q_hi;
  logic                 in_range;
  logic [DW-1:0]        q_result;

  // Datapath: accumulate the current product, quantize and range-check the sum.
  always_comb begin
    p_ext    = AW'($signed(mul_p));
    acc_sum  = (tap_q < 3'd3) ? (acc_q + p_ext) : (acc_q - p_ext);
    q_full   = acc_sum >>> SHIFT;
    q_hi     = q_full[AW-1:DW-1];
    in_range = (q_hi == '0) || (q_hi == '1);
`ifdef IIR_SAT_EN
    if (in_range) q_result = q_full[DW-1:0];
    else if (q_full[AW-1]) q_result = {1'b1, {(DW-1){1'b0}}};
    else q_result = {1'b0, {(DW-1){1'b1}}};
`else
    q_result = q_full[DW-1:0];
`endif
  end

  // Next-state, coefficient bank, history and registered-output logic.
  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    acc_d       = acc_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    in_ready_d  = in_ready_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    mul_a_d     = '0;
    mul_b_d     = '0;
    ovf_set     = 1'b0;

    for (int i = 0; i < NC; i++) begin
      if (coef_wr && (coef_addr == 3'(i))) shadow_d[i] = coef_data;
    end

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          // Snapshot uses the pre-write shadow bank.
          x0_d       = in_data;
          acc_d      = '0;
          active_d   = shadow_q;
          tap_d      = '0;
          mul_a_d    = in_data;
          mul_b_d    = shadow_q[0];
          in_ready_d = 1'b0;
          state_d    = S_MAC;
        end
      end
      S_MAC: begin
        acc_d   = acc_sum;
        ovf_set = mul_ovf;
        if (tap_q == 3'd4) begin
          out_data_d  = q_result;
          out_valid_d = 1'b1;
          x2_d        = x1_q;
          x1_d        = x0_q;
          y2_d        = y1_q;
          y1_d        = q_result;
          if (!in_range) ovf_set = 1'b1;
          state_d     = S_OUT;
        end else begin
          tap_d = tap_q + 3'd1;
          unique case (tap_q)
            3'd0:    begin mul_a_d = x1_q; mul_b_d = active_q[1]; end
            3'd1:    begin mul_a_d = x2_q; mul_b_d = active_q[2]; end
            3'd2:    begin mul_a_d = y1_q; mul_b_d = active_q[3]; end
            default: begin mul_a_d = y2_q; mul_b_d = active_q[4]; end
          endcase
        end
      end
      S_OUT: begin
        in_ready_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        in_ready_d = 1'b1;
        state_d    = S_IDLE;
      end
    endcase

    // A new overflow in the same cycle as a clear keeps the flag set.
    ovf_d = ovf_set | (ovf_q & ~ovf_clr);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tap_q       <= '0;
      acc_q       <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
      for (int i = 0; i < NC; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      acc_q       <= acc_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign ovf       = ovf_q;

endmodule
